// File: rtl/alu_exec_stage.sv
// Execute stage in front of the 8x8 register bank: operand read, single-cycle ALU
// or shift-add multiply, write-back through the bank write port, zero/carry flags.
module alu_exec_stage #(
   parameter int MUL_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       instr_valid,
   output logic       instr_ready,
   input  logic [3:0] instr_op,
   input  logic [2:0] instr_rd,
   input  logic [2:0] instr_rs1,
   input  logic [2:0] instr_rs2,
   input  logic [7:0] instr_imm,
   output logic [2:0] reg_addr_1,
   output logic [2:0] reg_addr_2,
   input  logic [7:0] reg_data_1,
   input  logic [7:0] reg_data_2,
   output logic       write_enable,
   output logic [2:0] write_addr,
   output logic [7:0] write_data,
   output logic       done,
   output logic       illegal,
   output logic       flag_z,
   output logic       flag_c
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_READ = 2'd1;
   localparam logic [1:0] S_EXEC = 2'd2;
   localparam logic [1:0] S_WB   = 2'd3;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SHL  = 4'd5;
   localparam logic [3:0] OP_SHR  = 4'd6;
   localparam logic [3:0] OP_MUL  = 4'd7;
   localparam logic [3:0] OP_ADDI = 4'd8;
   localparam logic [3:0] OP_LI   = 4'd9;

   localparam logic [3:0] CNT_LAST = 4'(MUL_CYCLES - 1);

   typedef struct packed {
      logic [3:0] op;
      logic [2:0] rd;
      logic [2:0] rs1;
      logic [2:0] rs2;
      logic [7:0] imm;
   } instr_t;

   logic [1:0] state;
   instr_t     ins;
   logic [7:0] opa, opb;
   logic [7:0] res;
   logic       res_c;
   logic [7:0] acc, mcand, mplier, acc_next;
   logic [3:0] cnt;
   logic [7:0] alu_res;
   logic       alu_c;
   logic [8:0] sum9;
   logic       legal, is_mul, run, in_wb;

   assign legal  = (ins.op <= OP_LI);
   assign is_mul = (ins.op == OP_MUL);
   // Outputs are forced low while rst is asserted so an abort never leaks a write.
   assign run    = !rst;
   assign in_wb  = run && (state == S_WB);

   assign instr_ready  = run && (state == S_IDLE);
   assign reg_addr_1   = (run && state != S_IDLE) ? ins.rs1 : 3'd0;
   assign reg_addr_2   = (run && state != S_IDLE) ? ins.rs2 : 3'd0;
   // Bank aliases address 0 onto X1, so rd=0 must never write.
   assign write_enable = in_wb && legal && (ins.rd != 3'd0);
   assign write_addr   = in_wb ? ins.rd : 3'd0;
   assign write_data   = in_wb ? res : 8'd0;
   assign done         = in_wb;
   assign illegal      = in_wb && !legal;

   assign acc_next = mplier[0] ? (acc + mcand) : acc;

   always_comb begin
      alu_res = 8'd0;
      alu_c   = 1'b0;
      sum9    = 9'd0;
      case (ins.op)
         OP_ADD: begin
            sum9    = {1'b0, opa} + {1'b0, opb};
            alu_res = sum9[7:0];
            alu_c   = sum9[8];
         end
         OP_SUB: begin
            alu_res = opa - opb;
            alu_c   = (opa < opb);
         end
         OP_AND:  alu_res = opa & opb;
         OP_OR:   alu_res = opa | opb;
         OP_XOR:  alu_res = opa ^ opb;
         OP_SHL:  alu_res = opa << opb[2:0];
         OP_SHR:  alu_res = opa >> opb[2:0];
         OP_ADDI: begin
            sum9    = {1'b0, opa} + {1'b0, ins.imm};
            alu_res = sum9[7:0];
            alu_c   = sum9[8];
         end
         OP_LI:   alu_res = ins.imm;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         ins    <= '0;
         opa    <= 8'd0;
         opb    <= 8'd0;
         res    <= 8'd0;
         res_c  <= 1'b0;
         acc    <= 8'd0;
         mcand  <= 8'd0;
         mplier <= 8'd0;
         cnt    <= 4'd0;
         flag_z <= 1'b0;
         flag_c <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (instr_valid) begin
                  ins   <= '{op: instr_op, rd: instr_rd, rs1: instr_rs1,
                             rs2: instr_rs2, imm: instr_imm};
                  state <= S_READ;
               end
            end
            S_READ: begin
               opa    <= reg_data_1;
               opb    <= reg_data_2;
               acc    <= 8'd0;
               mcand  <= reg_data_1;
               mplier <= reg_data_2;
               cnt    <= 4'd0;
               state  <= S_EXEC;
            end
            S_EXEC: begin
               if (is_mul) begin
                  // Only the low 8 bits of the product are kept, so bits
                  // shifted out of the multiplicand are simply dropped.
                  acc    <= acc_next;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  cnt    <= cnt + 4'd1;
                  if (cnt == CNT_LAST) begin
                     res   <= acc_next;
                     res_c <= 1'b0;
                     state <= S_WB;
                  end
               end else begin
                  res   <= alu_res;
                  res_c <= alu_c;
                  state <= S_WB;
               end
            end
            default: begin
               if (write_enable) begin
                  flag_z <= (res == 8'd0);
                  flag_c <= res_c;
               end
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage with a bank model whose writes become
// readable two cycles after the write-back cycle.
module tb_alu_exec_stage;

   logic       clk = 1'b0;
   logic       rst;
   logic       instr_valid;
   logic       instr_ready;
   logic [3:0] instr_op;
   logic [2:0] instr_rd, instr_rs1, instr_rs2;
   logic [7:0] instr_imm;
   logic [2:0] reg_addr_1, reg_addr_2;
   logic [7:0] reg_data_1, reg_data_2;
   logic       write_enable;
   logic [2:0] write_addr;
   logic [7:0] write_data;
   logic       done, illegal, flag_z, flag_c;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic       we;
      logic [2:0] addr;
      logic [7:0] data;
      logic       ill;
      logic       z;
      logic       c;
      int         exp_cyc;
   } exp_t;

   exp_t q[$];

   alu_exec_stage #(.MUL_CYCLES(8)) dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
      .instr_rs2(instr_rs2), .instr_imm(instr_imm),
      .reg_addr_1(reg_addr_1), .reg_addr_2(reg_addr_2),
      .reg_data_1(reg_data_1), .reg_data_2(reg_data_2),
      .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
      .done(done), .illegal(illegal), .flag_z(flag_z), .flag_c(flag_c)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Bank model: write captured at the WB edge, committed one edge later.
   logic [7:0] bank [8];
   logic       pw_en;
   logic [2:0] pw_addr;
   logic [7:0] pw_data;

   function automatic logic [2:0] bmap(input logic [2:0] a);
      return (a == 3'd0) ? 3'd1 : a;
   endfunction

   initial begin
      for (int i = 0; i < 8; i++) bank[i] = 8'd0;
      pw_en = 1'b0; pw_addr = 3'd0; pw_data = 8'd0;
   end

   always @(posedge clk) begin
      if (pw_en) bank[bmap(pw_addr)] <= pw_data;
      pw_en   <= write_enable;
      pw_addr <= write_addr;
      pw_data <= write_data;
   end

   assign reg_data_1 = bank[bmap(reg_addr_1)];
   assign reg_data_2 = bank[bmap(reg_addr_2)];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compare each retirement against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done) begin
            if (q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               e = q.pop_front();
               check("done_cycle", cyc, e.exp_cyc);
               check("write_enable", int'(write_enable), int'(e.we));
               check("illegal", int'(illegal), int'(e.ill));
               if (e.we) begin
                  check("write_addr", int'(write_addr), int'(e.addr));
                  check("write_data", int'(write_data), int'(e.data));
               end
               @(posedge clk);
               #1;
               check("flag_z", int'(flag_z), int'(e.z));
               check("flag_c", int'(flag_c), int'(e.c));
            end
         end
      end
   end

   task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic [7:0] imm, input bit push,
                        input bit we, input logic [7:0] d, input bit ill,
                        input bit z, input bit c, input int lat);
      int n = 0;
      exp_t e;
      @(negedge clk);
      while (!instr_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!instr_ready) begin
         check("ready_timeout", 0, 1);
         return;
      end
      instr_valid = 1'b1;
      instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
      if (push) begin
         e.we = we; e.addr = rd; e.data = d; e.ill = ill; e.z = z; e.c = c;
         e.exp_cyc = cyc + lat;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
   endtask

   localparam int LS = 3;   // single-cycle: accept edge + 2 at the WB negedge
   localparam int LM = 10;  // MUL: accept edge + 9 at the WB negedge

   initial begin
      int n;
      rst = 1'b1;
      instr_valid = 1'b0;
      instr_op = 4'd0; instr_rd = 3'd0; instr_rs1 = 3'd0; instr_rs2 = 3'd0; instr_imm = 8'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b1;
      #1;
      check("rst_ready", int'(instr_ready), 0);
      check("rst_done", int'(done), 0);
      check("rst_we", int'(write_enable), 0);
      check("rst_addr1", int'(reg_addr_1), 0);
      check("rst_flags", int'({flag_z, flag_c}), 0);
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("ready_after_rst", int'(instr_ready), 1);

      // ops: 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SHL,6 SHR,7 MUL,8 ADDI,9 LI
      issue(4'd9, 3'd1, 3'd0, 3'd0, 8'h05, 1, 1, 8'h05, 0, 0, 0, LS);
      issue(4'd9, 3'd2, 3'd0, 3'd0, 8'h03, 1, 1, 8'h03, 0, 0, 0, LS);
      issue(4'd0, 3'd3, 3'd1, 3'd2, 8'h00, 1, 1, 8'h08, 0, 0, 0, LS);

      issue(4'd9, 3'd1, 3'd0, 3'd0, 8'hF0, 1, 1, 8'hF0, 0, 0, 0, LS);
      issue(4'd9, 3'd2, 3'd0, 3'd0, 8'h20, 1, 1, 8'h20, 0, 0, 0, LS);
      issue(4'd0, 3'd4, 3'd1, 3'd2, 8'h00, 1, 1, 8'h10, 0, 0, 1, LS);
      issue(4'd1, 3'd5, 3'd2, 3'd1, 8'h00, 1, 1, 8'h30, 0, 0, 1, LS);
      issue(4'd1, 3'd5, 3'd1, 3'd1, 8'h00, 1, 1, 8'h00, 0, 1, 0, LS);
      issue(4'd3, 3'd3, 3'd1, 3'd2, 8'h00, 1, 1, 8'hF0, 0, 0, 0, LS);
      issue(4'd4, 3'd3, 3'd1, 3'd2, 8'h00, 1, 1, 8'hD0, 0, 0, 0, LS);

      // r2=0x03: shifts by 3, AND yields zero
      issue(4'd9, 3'd2, 3'd0, 3'd0, 8'h03, 1, 1, 8'h03, 0, 0, 0, LS);
      issue(4'd5, 3'd3, 3'd1, 3'd2, 8'h00, 1, 1, 8'h80, 0, 0, 0, LS);
      issue(4'd6, 3'd3, 3'd1, 3'd2, 8'h00, 1, 1, 8'h1E, 0, 0, 0, LS);
      issue(4'd2, 3'd3, 3'd1, 3'd2, 8'h00, 1, 1, 8'h00, 0, 1, 0, LS);

      issue(4'd9, 3'd1, 3'd0, 3'd0, 8'h0D, 1, 1, 8'h0D, 0, 0, 0, LS);
      issue(4'd9, 3'd2, 3'd0, 3'd0, 8'h0B, 1, 1, 8'h0B, 0, 0, 0, LS);
      issue(4'd7, 3'd6, 3'd1, 3'd2, 8'h00, 1, 1, 8'h8F, 0, 0, 0, LM);
      issue(4'd9, 3'd1, 3'd0, 3'd0, 8'h20, 1, 1, 8'h20, 0, 0, 0, LS);
      issue(4'd9, 3'd2, 3'd0, 3'd0, 8'h10, 1, 1, 8'h10, 0, 0, 0, LS);
      issue(4'd7, 3'd6, 3'd1, 3'd2, 8'h00, 1, 1, 8'h00, 0, 1, 0, LM);

      // rd=0 and illegal opcode: retire without writing, flags hold z=1,c=0
      issue(4'd0, 3'd0, 3'd1, 3'd2, 8'h00, 1, 0, 8'h00, 0, 1, 0, LS);
      issue(4'd12, 3'd3, 3'd1, 3'd2, 8'h00, 1, 0, 8'h00, 1, 1, 0, LS);

      // dependent back-to-back: ADDI must see the fresh r1
      issue(4'd9, 3'd1, 3'd0, 3'd0, 8'h7F, 1, 1, 8'h7F, 0, 0, 0, LS);
      issue(4'd8, 3'd1, 3'd1, 3'd0, 8'h01, 1, 1, 8'h80, 0, 0, 0, LS);
      issue(4'd8, 3'd2, 3'd1, 3'd0, 8'h90, 1, 1, 8'h10, 0, 0, 1, LS);

      // reset during MUL execution aborts it
      issue(4'd7, 3'd6, 3'd1, 3'd2, 8'h00, 0, 0, 8'h00, 0, 0, 0, LM);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_we", int'(write_enable), 0);
      check("abort_done", int'(done), 0);
      check("abort_ready", int'(instr_ready), 0);
      check("abort_addr1", int'(reg_addr_1), 0);
      @(posedge clk);
      #1;
      check("abort_flags", int'({flag_z, flag_c}), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_ready_after", int'(instr_ready), 1);
      repeat (12) @(negedge clk);
      issue(4'd9, 3'd3, 3'd0, 3'd0, 8'h55, 1, 1, 8'h55, 0, 0, 0, LS);

      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) check("drain_timeout", q.size(), 0);
      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
